// File: rtl/regfile_pkg.sv
// Shared constants and entry type for the register-file write queue.
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wrq_entry_t;

endpackage

// File: rtl/wrq_match.sv
// Youngest-first priority matcher over the write-queue entries; one instance per lookup port.
module wrq_match
    import regfile_pkg::*;
#(
    parameter int unsigned N     = REG_AW,
    parameter int unsigned M     = REG_DW,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][N-1:0] addrs,
    input  logic [DEPTH-1:0][M-1:0] datas,
    input  logic [DEPTH-1:0]        valid,
    input  logic [PW-1:0]           head,
    input  logic [N-1:0]            q,
    output logic                    hit,
    output logic [M-1:0]            data
);

    logic [PW-1:0] idx;

    // Walk from oldest (head) to youngest so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (addrs[idx] == q) && (q != N'(REG_ZERO))) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wr_queue.sv
// In-order write queue feeding the register-file write port, with two forwarding lookups.
// Optional same-register coalescing is enabled by defining REGFILE_WR_QUEUE_COALESCE_EN.
module regfile_wr_queue
    import regfile_pkg::*;
#(
    parameter int unsigned N     = REG_AW,
    parameter int unsigned M     = REG_DW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_addr,
    input  logic [M-1:0]             in_data,
    input  logic                     wr_stall,
    output logic [N-1:0]             a3,
    output logic [M-1:0]             wd3,
    output logic                     we3,
    input  logic [N-1:0]             q1,
    output logic                     hit1,
    output logic [M-1:0]             fwd1,
    input  logic [N-1:0]             q2,
    output logic                     hit2,
    output logic [M-1:0]             fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0][N-1:0] addr_q;
    logic [DEPTH-1:0][M-1:0] data_q;
    logic [DEPTH-1:0]        valid_q;
    logic [PW-1:0]           head_q, tail_q;
    logic [CW-1:0]           count_q;
    logic                    nonempty, pop, push, alloc, coal;
`ifdef REGFILE_WR_QUEUE_COALESCE_EN
    logic [PW-1:0]           young;
`endif

    always_comb begin
        nonempty = (count_q != '0);
        we3      = nonempty && !wr_stall;
        pop      = we3;
`ifdef REGFILE_WR_QUEUE_COALESCE_EN
        young    = tail_q - PW'(1);
        // The youngest entry is the head only when one entry remains.
        coal     = nonempty && (addr_q[young] == in_addr) && !(pop && (count_q == CW'(1)));
`else
        coal     = 1'b0;
`endif
        in_ready = (count_q < CW'(DEPTH)) || coal;
        push     = in_valid && in_ready;
        // Writes to $0 are accepted but never stored.
        alloc    = push && (in_addr != N'(REG_ZERO)) && !coal;
        a3       = nonempty ? addr_q[head_q] : '0;
        wd3      = nonempty ? data_q[head_q] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            if (alloc) begin
                addr_q[tail_q]  <= in_addr;
                data_q[tail_q]  <= in_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
`ifdef REGFILE_WR_QUEUE_COALESCE_EN
            if (push && coal) begin
                data_q[young] <= in_data;
            end
`endif
            count_q <= count_q + CW'(alloc) - CW'(pop);
        end
    end

    assign count = count_q;

    wrq_match #(.N(N), .M(M), .DEPTH(DEPTH)) u_match1 (
        .addrs (addr_q),
        .datas (data_q),
        .valid (valid_q),
        .head  (head_q),
        .q     (q1),
        .hit   (hit1),
        .data  (fwd1)
    );

    wrq_match #(.N(N), .M(M), .DEPTH(DEPTH)) u_match2 (
        .addrs (addr_q),
        .datas (data_q),
        .valid (valid_q),
        .head  (head_q),
        .q     (q2),
        .hit   (hit2),
        .data  (fwd2)
    );

endmodule

// File: tb/tb_regfile_wr_queue.sv
// Directed table-driven bench for regfile_wr_queue plus wrap and async-reset sequences.
module tb_regfile_wr_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_stall;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic [4:0]  q1, q2;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wr_queue #(.N(5), .M(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .a3       (a3),
        .wd3      (wd3),
        .we3      (we3),
        .q1       (q1),
        .hit1     (hit1),
        .fwd1     (fwd1),
        .q2       (q2),
        .hit2     (hit2),
        .fwd2     (fwd2),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] id;
        logic        st;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        rdy;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int iv, int ia, int id, int st, int qa, int qb, int rdy, int we,
                                int ea3, int ewd, int cnt, int h1, int f1, int h2, int f2);
        vec_t v;
        v.iv = 1'(iv);  v.ia = 5'(ia);  v.id = 32'(id);  v.st = 1'(st);
        v.q1 = 5'(qa);  v.q2 = 5'(qb);  v.rdy = 1'(rdy); v.we = 1'(we);
        v.a3 = 5'(ea3); v.wd = 32'(ewd); v.cnt = 3'(cnt);
        v.h1 = 1'(h1);  v.f1 = 32'(f1); v.h2 = 1'(h2);   v.f2 = 32'(f2);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t model[$];

    initial begin
        string tag;
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wr_stall = 1'b0; q1 = '0; q2 = '0;

        // Reset state
        #12;
        chk("rst_we3", 32'(we3), 0);
        chk("rst_a3", 32'(a3), 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_hit1", 32'(hit1), 0);
        chk("rst_hit2", 32'(hit2), 0);
        chk("rst_fwd1", fwd1, 0);
        chk("rst_fwd2", fwd2, 0);
        #5 rst_n = 1'b1;

        // iv ia id st q1 q2 | rdy we a3 wd cnt h1 f1 h2 f2
        vecs.push_back(mk(1, 3, 100, 0, 3, 0,  1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0,    1, 1, 3, 100, 1,  1, 100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0,    1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 11, 1, 2, 1,   1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 22, 1, 2, 1,   1, 0, 1, 11, 1,   0, 0, 1, 11));
        vecs.push_back(mk(1, 3, 33, 1, 2, 1,   1, 0, 1, 11, 2,   1, 22, 1, 11));
        vecs.push_back(mk(1, 4, 44, 1, 2, 1,   1, 0, 1, 11, 3,   1, 22, 1, 11));
        vecs.push_back(mk(1, 5, 55, 1, 2, 1,   0, 0, 1, 11, 4,   1, 22, 1, 11));
        vecs.push_back(mk(0, 0, 0, 1, 5, 1,    0, 0, 1, 11, 4,   0, 0, 1, 11));
        vecs.push_back(mk(0, 0, 0, 0, 5, 4,    0, 1, 1, 11, 4,   0, 0, 1, 44));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4,    1, 1, 2, 22, 3,   0, 0, 1, 44));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4,    1, 1, 3, 33, 2,   0, 0, 1, 44));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4,    1, 1, 4, 44, 1,   0, 0, 1, 44));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4,    1, 0, 0, 0, 0,    0, 0, 0, 0));
        // $0 write is swallowed
        vecs.push_back(mk(1, 0, 55, 0, 0, 0,   1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,    0, 0, 0, 0));
        // Two writes to $5: youngest data forwarded
        vecs.push_back(mk(1, 5, 7, 1, 5, 6,    1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 9, 1, 5, 6,    1, 0, 5, 7, 1,    1, 7, 0, 0));
`ifdef REGFILE_WR_QUEUE_COALESCE_EN
        vecs.push_back(mk(0, 0, 0, 1, 5, 6,    1, 0, 5, 9, 1,    1, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 6,    1, 1, 5, 9, 1,    1, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 6,    1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 6,    1, 0, 0, 0, 0,    0, 0, 0, 0));
`else
        vecs.push_back(mk(0, 0, 0, 1, 5, 6,    1, 0, 5, 7, 2,    1, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 6,    1, 1, 5, 7, 2,    1, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 6,    1, 1, 5, 9, 1,    1, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5, 6,    1, 0, 0, 0, 0,    0, 0, 0, 0));
`endif
        // Full queue: push refused while popping
        vecs.push_back(mk(1, 6, 60, 1, 0, 0,   1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 7, 70, 1, 0, 0,   1, 0, 6, 60, 1,   0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 80, 1, 0, 0,   1, 0, 6, 60, 2,   0, 0, 0, 0));
        vecs.push_back(mk(1, 9, 90, 1, 0, 0,   1, 0, 6, 60, 3,   0, 0, 0, 0));
        vecs.push_back(mk(1, 10, 100, 0, 0, 0, 0, 1, 6, 60, 4,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    1, 1, 7, 70, 3,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    1, 1, 8, 80, 2,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    1, 1, 9, 90, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,    0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].iv; in_addr = vecs[i].ia; in_data = vecs[i].id;
            wr_stall = vecs[i].st; q1 = vecs[i].q1; q2 = vecs[i].q2;
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, "_ready"}, 32'(in_ready), 32'(vecs[i].rdy));
            chk({tag, "_we3"}, 32'(we3), 32'(vecs[i].we));
            chk({tag, "_a3"}, 32'(a3), 32'(vecs[i].a3));
            chk({tag, "_wd3"}, wd3, vecs[i].wd);
            chk({tag, "_count"}, 32'(count), 32'(vecs[i].cnt));
            chk({tag, "_hit1"}, 32'(hit1), 32'(vecs[i].h1));
            chk({tag, "_fwd1"}, fwd1, vecs[i].f1);
            chk({tag, "_hit2"}, 32'(hit2), 32'(vecs[i].h2));
            chk({tag, "_fwd2"}, fwd2, vecs[i].f2);
        end

        // Pointer wrap: 3*DEPTH pushes with random stalls, scoreboard-checked drain order
        begin
            int pushes = 0;
            int cyc = 0;
            logic exp_rdy, exp_we;
            q1 = '0; q2 = '0;
            while ((pushes < 3 * DEPTH || model.size() != 0) && cyc < 400) begin
                @(negedge clk);
                cyc++;
                in_valid = (pushes < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
                in_addr  = 5'((pushes % 31) + 1);
                in_data  = $urandom;
                wr_stall = ($urandom_range(0, 2) == 0);
                #1;
                exp_rdy = (model.size() < DEPTH);
                exp_we  = (model.size() != 0) && !wr_stall;
                chk("wrap_ready", 32'(in_ready), 32'(exp_rdy));
                chk("wrap_we3", 32'(we3), 32'(exp_we));
                chk("wrap_count", 32'(count), 32'(model.size()));
                if (exp_we) begin
                    chk("wrap_a3", 32'(a3), 32'(model[0].addr));
                    chk("wrap_wd3", wd3, model[0].data);
                    void'(model.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    model.push_back('{addr: in_addr, data: in_data});
                    pushes++;
                end
            end
            chk("wrap_done", 32'(pushes == 3 * DEPTH && model.size() == 0), 1);
        end

        // Asynchronous reset mid-cycle with three queued writes
        @(negedge clk);
        in_valid = 1'b1; wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_addr = 5'(11 + i); in_data = 32'(1000 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        wr_stall = 1'b0;
        #1;
        chk("prerst_we3", 32'(we3), 1);
        chk("prerst_count", 32'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("arst_we3", 32'(we3), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_a3", 32'(a3), 0);
        chk("arst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_we3", 32'(we3), 0);
            chk("postrst_count", 32'(count), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
